// File: rtl/instr_encoder.sv
// RV32I instruction packer: turns decoded fields plus a 32-bit immediate into
// address-tagged instruction words held in a 2-entry FIFO.
// Optional macro INSTR_ENC_RANGE_CHECK_EN enables immediate/format checks (out_err, err_sticky).
module instr_encoder #(
  parameter int                 ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]  RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_base,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic              err_sticky
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  logic [31:0]       enc_word;
  logic [1:0]        count;
  logic              wr_ptr;
  logic              rd_ptr;
  logic [31:0]       buf_instr [2];
  logic [ADDR_W-1:0] buf_addr  [2];
  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W-1:0] tag_addr;
  logic              push;
  logic              pop;

  // Bit scatter follows the RV32I immediate layouts; illegal formats become a NOP.
  always_comb begin
    enc_word = NOP_WORD;
    case (fmt)
      FMT_R: enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: enc_word = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S: enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B: enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U: enc_word = {imm[31:12], rd, opcode};
      FMT_J: enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: enc_word = NOP_WORD;
    endcase
  end

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign tag_addr  = addr_load ? addr_base : addr_cnt;
  assign out_instr = buf_instr[rd_ptr];
  assign out_addr  = buf_addr[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_instr[i] <= '0;
        buf_addr[i]  <= '0;
      end
    end else begin
      if (push) begin
        buf_instr[wr_ptr] <= enc_word;
        buf_addr[wr_ptr]  <= tag_addr;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

  // A load coincident with an accept tags that bundle with the new base.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_cnt <= RESET_ADDR;
    end else if (push) begin
      addr_cnt <= tag_addr + ADDR_W'(4);
    end else if (addr_load) begin
      addr_cnt <= addr_base;
    end
  end

`ifdef INSTR_ENC_RANGE_CHECK_EN
  logic enc_err;
  logic fits_12;
  logic fits_13;
  logic fits_21;
  logic buf_err [2];
  logic sticky_q;

  assign fits_12 = (imm[31:11] == '0) || (imm[31:11] == '1);
  assign fits_13 = (imm[31:12] == '0) || (imm[31:12] == '1);
  assign fits_21 = (imm[31:20] == '0) || (imm[31:20] == '1);

  always_comb begin
    enc_err = 1'b1;
    case (fmt)
      FMT_R:        enc_err = 1'b0;
      FMT_I, FMT_S: enc_err = !fits_12;
      FMT_B:        enc_err = !fits_13 || imm[0];
      FMT_U:        enc_err = (imm[11:0] != 12'd0);
      FMT_J:        enc_err = !fits_21 || imm[0];
      default:      enc_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_err[0] <= 1'b0;
      buf_err[1] <= 1'b0;
      sticky_q   <= 1'b0;
    end else if (push) begin
      buf_err[wr_ptr] <= enc_err;
      if (enc_err) begin
        sticky_q <= 1'b1;
      end
    end
  end

  assign out_err    = buf_err[rd_ptr];
  assign err_sticky = sticky_q;
`else
  assign out_err    = 1'b0;
  assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: hand-computed vector table plus a
// scoreboard of expected words, and sequences for backpressure and reset.
module tb_instr_encoder;

`ifdef INSTR_ENC_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        load;
    logic [31:0] base;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  fmt = '0;
  logic [6:0]  opcode = '0;
  logic [4:0]  rd = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [31:0] imm = '0;
  logic        addr_load = 1'b0;
  logic [31:0] addr_base = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;
  logic        err_sticky;

  int          errors = 0;
  int          checks = 0;
  vec_t        vecs[$];
  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] addr_model = 32'h0;

  instr_encoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .fmt        (fmt),
    .opcode     (opcode),
    .rd         (rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .funct3     (funct3),
    .funct7     (funct7),
    .imm        (imm),
    .addr_load  (addr_load),
    .addr_base  (addr_base),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_addr   (out_addr),
    .out_err    (out_err),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic addVec(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] im, input logic ld,
                        input logic [31:0] bs, input logic [31:0] ei, input logic ee);
    vec_t v;
    v = '{fmt: f, opcode: op, rd: d, rs1: s1, rs2: s2, funct3: f3, funct7: f7,
          imm: im, load: ld, base: bs, exp_instr: ei, exp_err: ee};
    vecs.push_back(v);
  endtask

  // Drives one bundle from posedge+1, holding it until accepted; records the expected word.
  task automatic applyStimulus(input vec_t v);
    int          waited;
    logic [31:0] tag;
    exp_t        e;
    waited    = 0;
    fmt       = v.fmt;
    opcode    = v.opcode;
    rd        = v.rd;
    rs1       = v.rs1;
    rs2       = v.rs2;
    funct3    = v.funct3;
    funct7    = v.funct7;
    imm       = v.imm;
    addr_load = v.load;
    addr_base = v.base;
    in_valid  = 1'b1;
    while (!in_ready && waited < 50) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: in_ready stayed 0 for %0d cycles", waited);
      in_valid  = 1'b0;
      addr_load = 1'b0;
      return;
    end
    tag        = v.load ? v.base : addr_model;
    addr_model = tag + 32'd4;
    e = '{instr: v.exp_instr, addr: tag, err: v.exp_err & RC};
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    addr_load = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain_left", 32'(sb.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_word: got %08h at %08h expected none", out_instr, out_addr);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("out_instr", out_instr, mon_e.instr);
        checkOutput("out_addr", out_addr, mon_e.addr);
        checkOutput("out_err", 32'(out_err), 32'(mon_e.err));
      end
    end
  end

  initial begin
    //      fmt   op     rd     rs1    rs2    f3    f7      imm           ld    base          expected      err
    addVec(3'd1, 7'h13, 5'd1,  5'd0,  5'h1f, 3'd0, 7'h7f, 32'd5,        1'b0, 32'h0,        32'h00500093, 1'b0);
    addVec(3'd2, 7'h23, 5'h1f, 5'd1,  5'd2,  3'd2, 7'h7f, 32'd8,        1'b0, 32'h0,        32'h0020A423, 1'b0);
    addVec(3'd5, 7'h6f, 5'd1,  5'h1f, 5'h1f, 3'd7, 7'h7f, 32'd8,        1'b1, 32'h100,      32'h008000EF, 1'b0);
    addVec(3'd0, 7'h33, 5'd3,  5'd1,  5'd2,  3'd0, 7'h00, 32'hFFFFFFFF, 1'b0, 32'h0,        32'h002081B3, 1'b0);
    addVec(3'd0, 7'h33, 5'd3,  5'd1,  5'd2,  3'd0, 7'h20, 32'h0,        1'b0, 32'h0,        32'h402081B3, 1'b0);
    addVec(3'd3, 7'h63, 5'h1f, 5'd1,  5'd2,  3'd0, 7'h7f, 32'hFFFFFFFC, 1'b0, 32'h0,        32'hFE208EE3, 1'b0);
    addVec(3'd4, 7'h37, 5'd5,  5'd3,  5'd4,  3'd7, 7'h7f, 32'h12345000, 1'b0, 32'h0,        32'h123452B7, 1'b0);
    addVec(3'd1, 7'h13, 5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 32'hFFFFFFFF, 1'b0, 32'h0,        32'hFFF00093, 1'b0);
    addVec(3'd1, 7'h13, 5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 32'hFFFFF800, 1'b0, 32'h0,        32'h80000093, 1'b0);
    addVec(3'd2, 7'h23, 5'h1f, 5'd0,  5'd0,  3'd0, 7'h00, 32'hFFFFFFFF, 1'b0, 32'h0,        32'hFE000FA3, 1'b0);
    addVec(3'd3, 7'h63, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'hFFFFF000, 1'b0, 32'h0,        32'h80000063, 1'b0);
    addVec(3'd5, 7'h6f, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'hFFF00000, 1'b0, 32'h0,        32'h8000006F, 1'b0);
    addVec(3'd1, 7'h13, 5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 32'h00000800, 1'b0, 32'h0,        32'h80000093, 1'b1);
    addVec(3'd3, 7'h63, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h00000003, 1'b0, 32'h0,        32'h00000163, 1'b1);
    addVec(3'd3, 7'h63, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h00001000, 1'b0, 32'h0,        32'h80000063, 1'b1);
    addVec(3'd4, 7'h37, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h00001001, 1'b0, 32'h0,        32'h00001037, 1'b1);
    addVec(3'd5, 7'h6f, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h00100000, 1'b0, 32'h0,        32'h8000006F, 1'b1);
    addVec(3'd5, 7'h6f, 5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 32'h00000001, 1'b0, 32'h0,        32'h000000EF, 1'b1);
    addVec(3'd6, 7'h7f, 5'h1f, 5'h1f, 5'h1f, 3'd7, 7'h7f, 32'hFFFFFFFF, 1'b0, 32'h0,        32'h00000013, 1'b1);
    addVec(3'd7, 7'h55, 5'h0a, 5'h0b, 5'h0c, 3'd5, 7'h2a, 32'h12345678, 1'b0, 32'h0,        32'h00000013, 1'b1);
    addVec(3'd1, 7'h13, 5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 32'd5,        1'b1, 32'hFFFFFFFC, 32'h00500093, 1'b0);
    addVec(3'd1, 7'h13, 5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 32'd5,        1'b0, 32'h0,        32'h00500093, 1'b0);

    out_ready = 1'b1;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_instr", out_instr, 32'd0);
    checkOutput("rst_out_addr", out_addr, 32'd0);
    checkOutput("rst_out_err", 32'(out_err), 32'd0);
    checkOutput("rst_err_sticky", 32'(err_sticky), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // First word must reach the head one cycle after acceptance.
    applyStimulus(vecs[0]);
    checkOutput("latency_valid", 32'(out_valid), 32'd1);
    for (int i = 1; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      if (i == 11) checkOutput("sticky_clean", 32'(err_sticky), 32'd0);
    end
    waitDrain();
    checkOutput("sticky_held", 32'(err_sticky), 32'(RC));

    // Backpressure: two words fill the buffer, the third waits for a pop.
    out_ready = 1'b0;
    applyStimulus(vecs[0]);
    applyStimulus(vecs[1]);
    checkOutput("bp_full_in_ready", 32'(in_ready), 32'd0);
    fork
      applyStimulus(vecs[3]);
      begin
        repeat (3) begin
          @(posedge clk);
          #1;
        end
        checkOutput("bp_hold_in_ready", 32'(in_ready), 32'd0);
        checkOutput("bp_hold_instr", out_instr, sb[0].instr);
        checkOutput("bp_hold_addr", out_addr, sb[0].addr);
        out_ready = 1'b1;
        #1;
        checkOutput("bp_no_bypass", 32'(in_ready), 32'd0);
      end
    join
    waitDrain();

    // Reset with two words buffered drops them and restarts the counter.
    out_ready = 1'b0;
    applyStimulus(vecs[12]);
    applyStimulus(vecs[1]);
    checkOutput("pre_rst_valid", 32'(out_valid), 32'd1);
    checkOutput("pre_rst_sticky", 32'(err_sticky), 32'(RC));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("arst_err_sticky", 32'(err_sticky), 32'd0);
    checkOutput("arst_out_addr", out_addr, 32'd0);
    checkOutput("arst_out_instr", out_instr, 32'd0);
    checkOutput("arst_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    addr_model = 32'h0;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    applyStimulus(vecs[0]);
    waitDrain();
    checkOutput("post_rst_sticky", 32'(err_sticky), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
